// File: rtl/fp32_pkg.sv
// fp32_pkg: FP32 field widths and the align-stage bundle shared by the adder datapath
package fp32_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MAN_W  = 24;
  localparam int ALN_W  = 27;

  typedef struct packed {
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] big_man;
    logic [MAN_W-1:0] small_man;
    logic             sign;
    logic             eff_sub;
    logic             swap;
    logic [4:0]       shamt;
    logic             far;
  } s1_t;

  function automatic logic [MAN_W-1:0] man_of(input logic [31:0] f);
    return {|f[FRAC_W +: EXP_W], f[FRAC_W-1:0]};
  endfunction
endpackage

// File: rtl/shr_sticky27.sv
// shr_sticky27: 27-bit logical right shift that folds every shifted-out bit into bit0
module shr_sticky27
  import fp32_pkg::*;
(
  input  logic [ALN_W-1:0] x,
  input  logic [4:0]       sh,
  output logic [ALN_W-1:0] y
);
  logic [ALN_W-1:0] lost_mask;
  assign lost_mask = ~({ALN_W{1'b1}} << sh);
  assign y = (x >> sh) | {{(ALN_W-1){1'b0}}, |(x & lost_mask)};
endmodule

// File: rtl/fp_align_stage.sv
// fp_align_stage: swaps FP32 operands by exponent and aligns the small mantissa with G/R/S
module fp_align_stage
  import fp32_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_a,
  input  logic [31:0]        in_b,
  input  logic               in_op,
  input  logic               in_lt,
  input  logic [4:0]         in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EXP_W-1:0]   out_exp,
  output logic [MAN_W-1:0]   out_big_man,
  output logic [ALN_W-1:0]   out_small_man,
  output logic               out_sign,
  output logic               out_eff_sub,
  output logic               out_swap
);
  s1_t s1_d, s1_q;
  logic s1_v, s1_adv, s2_load;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [ALN_W-1:0] shifted, aligned;

  assign exp_a    = in_a[FRAC_W +: EXP_W];
  assign exp_b    = in_b[FRAC_W +: EXP_W];
  assign s2_load  = ~out_valid | out_ready;
  assign s1_adv   = ~s1_v | s2_load;
  assign in_ready = s1_adv;

  always_comb begin
    s1_d.exp       = in_lt ? exp_b : exp_a;
    s1_d.big_man   = in_lt ? man_of(in_b) : man_of(in_a);
    s1_d.small_man = in_lt ? man_of(in_a) : man_of(in_b);
    s1_d.sign      = in_lt ? in_b[31] ^ in_op : in_a[31];
    s1_d.eff_sub   = in_a[31] ^ in_b[31] ^ in_op;
    s1_d.swap      = in_lt;
    s1_d.shamt     = in_shamt;
    s1_d.far       = (in_shamt == 5'd0) && (exp_a != exp_b);
  end

  shr_sticky27 u_shr (
    .x  ({s1_q.small_man, 3'b000}),
    .sh (s1_q.shamt),
    .y  (shifted)
  );

  // a zero shamt with unequal exponents means the gap overflowed: only sticky survives
  assign aligned = s1_q.far ? {{(ALN_W-1){1'b0}}, |s1_q.small_man} : shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v          <= 1'b0;
      s1_q          <= '0;
      out_valid     <= 1'b0;
      out_exp       <= '0;
      out_big_man   <= '0;
      out_small_man <= '0;
      out_sign      <= 1'b0;
      out_eff_sub   <= 1'b0;
      out_swap      <= 1'b0;
    end else begin
      if (s1_adv) s1_v <= in_valid;
      if (s1_adv && in_valid) s1_q <= s1_d;
      if (s2_load) out_valid <= s1_v;
      if (s2_load && s1_v) begin
        out_exp       <= s1_q.exp;
        out_big_man   <= s1_q.big_man;
        out_small_man <= aligned;
        out_sign      <= s1_q.sign;
        out_eff_sub   <= s1_q.eff_sub;
        out_swap      <= s1_q.swap;
      end
    end
  end
endmodule

// File: tb/tb_fp_align_stage.sv
// tb_fp_align_stage: directed checks of swap, alignment, sticky, backpressure and reset
module tb_fp_align_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_op = 1'b0, in_lt = 1'b0;
  logic [4:0]  in_shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_exp;
  logic [23:0] out_big_man;
  logic [26:0] out_small_man;
  logic        out_sign, out_eff_sub, out_swap;
  int n_pass = 0;
  int n_total = 0;

  fp_align_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_lt(in_lt), .in_shamt(in_shamt),
    .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp),
    .out_big_man(out_big_man), .out_small_man(out_small_man), .out_sign(out_sign),
    .out_eff_sub(out_eff_sub), .out_swap(out_swap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic lt, input logic [4:0] sh);
    in_a = a; in_b = b; in_op = op; in_lt = lt; in_shamt = sh;
  endtask

  // one bundle through an idle pipeline with out_ready high; checks 2-cycle latency and fields
  task automatic run1(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic op, input logic lt, input logic [4:0] sh,
                      input logic [7:0] e_exp, input logic [23:0] e_big,
                      input logic [26:0] e_small, input logic e_sign,
                      input logic e_eff, input logic e_swap);
    drive(a, b, op, lt, sh);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_exp"}, {24'b0, out_exp}, {24'b0, e_exp});
    check({tag, "_big"}, {8'b0, out_big_man}, {8'b0, e_big});
    check({tag, "_small"}, {5'b0, out_small_man}, {5'b0, e_small});
    check({tag, "_flags"}, {29'b0, out_sign, out_eff_sub, out_swap}, {29'b0, e_sign, e_eff, e_swap});
  endtask

  task automatic set_bp(input int i);
    drive({1'b0, 8'h80 + 8'(i), 23'h400000}, 32'h3F800000, 1'b0, 1'b0, 5'(i + 1));
  endtask

  function automatic logic [26:0] bp_small(input int i);
    logic [26:0] one_at_top;
    one_at_top = 27'h4000000;
    return one_at_top >> (i + 1);
  endfunction

  task automatic check_bp_out(input string tag, input int i);
    check({tag, "_v"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_exp"}, {24'b0, out_exp}, {24'b0, 8'h80 + 8'(i)});
    check({tag, "_small"}, {5'b0, out_small_man}, {5'b0, bp_small(i)});
  endtask

  initial begin
    #2;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_small", {5'b0, out_small_man}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run1("noswap", 32'h40400000, 32'h3F800000, 1'b0, 1'b0, 5'd1,
         8'h80, 24'hC00000, 27'h2000000, 1'b0, 1'b0, 1'b0);
    run1("swapsub", 32'h3F800000, 32'h40400000, 1'b1, 1'b1, 5'd1,
         8'h80, 24'hC00000, 27'h2000000, 1'b1, 1'b1, 1'b1);
    run1("far", 32'h64800000, 32'h3F800001, 1'b0, 1'b0, 5'd0,
         8'hC9, 24'h800000, 27'h0000001, 1'b0, 1'b0, 1'b0);
    run1("sticky25", 32'h4C000000, 32'h3F800001, 1'b0, 1'b0, 5'd25,
         8'h98, 24'h800000, 27'h0000003, 1'b0, 1'b0, 1'b0);
    run1("eqexp", 32'h3FC00000, 32'h3F800000, 1'b0, 1'b0, 5'd0,
         8'h7F, 24'hC00000, 27'h4000000, 1'b0, 1'b0, 1'b0);
    run1("negA", 32'hC0400000, 32'h3F800000, 1'b0, 1'b0, 5'd1,
         8'h80, 24'hC00000, 27'h2000000, 1'b1, 1'b1, 1'b0);
    run1("farzero", 32'h40400000, 32'h00000000, 1'b0, 1'b0, 5'd0,
         8'h80, 24'hC00000, 27'h0000000, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;

    out_ready = 1'b0;
    in_valid = 1'b1;
    set_bp(0);
    check("bp_rdy0", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    set_bp(1);
    check("bp_rdy1", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    set_bp(2);
    check("bp_full", {31'b0, in_ready}, 32'd0);
    check_bp_out("bp_hold0", 0);
    @(posedge clk); #1;
    check("bp_full2", {31'b0, in_ready}, 32'd0);
    check_bp_out("bp_hold1", 0);
    @(posedge clk); #1;
    check_bp_out("bp_hold2", 0);
    out_ready = 1'b1;
    #1 check("bp_release_rdy", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check_bp_out("bp_out1", 1);
    set_bp(3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_bp_out("bp_out2", 2);
    @(posedge clk); #1;
    check_bp_out("bp_out3", 3);
    @(posedge clk); #1;
    check("bp_drained", {31'b0, out_valid}, 32'd0);

    out_ready = 1'b0;
    in_valid = 1'b1;
    drive(32'h3F800000, 32'h40400000, 1'b1, 1'b1, 5'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_full", {31'b0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    check("rst_mid_data", {out_exp, out_big_man}, 32'd0);
    check("rst_mid_small", {5'b0, out_small_man}, 32'd0);
    check("rst_mid_flags", {29'b0, out_sign, out_eff_sub, out_swap}, 32'd0);
    check("rst_mid_rdy", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("post_rst_rdy", {31'b0, in_ready}, 32'd1);
    run1("post_rst", 32'h40400000, 32'h3F800000, 1'b0, 1'b0, 5'd1,
         8'h80, 24'hC00000, 27'h2000000, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
